issue_queue: RTL

// - Out-of-order issue window directly upstream of EXE. Holds renamed instructions from dispatch,

---
 rtl/iq_pkg.sv | 55 +++++
 rtl/iq_age_select.sv | 49 ++++
 rtl/issue_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared types and sizes for the out-of-order issue queue.
package iq_pkg;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned INFO_W = 35;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [TAG_W-1:0]  a_tag;
    logic              a_rdy;
    logic [31:0]       a_val;
    logic [TAG_W-1:0]  b_tag;
    logic              b_rdy;
    logic [31:0]       b_val;
    logic [TAG_W-1:0]  dest_map;
    logic [4:0]        wreg;
    logic              regwr;
    logic              memrd;
    logic              memwr;
    logic [5:0]        alu_ctl;
    logic [4:0]        shamt;
    logic [INFO_W-1:0] info;
  } iq_entry_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [31:0]       opa;
    logic [31:0]       opb;
    logic [4:0]        wreg;
    logic              regwr;
    logic [5:0]        alu_ctl;
    logic [4:0]        shamt;
    logic              memrd;
    logic              memwr;
    logic [INFO_W-1:0] info;
    logic [TAG_W-1:0]  map;
    logic              flag;
  } iq_issue_t;

  // A not-yet-ready source is woken by a matching valid broadcast.
  function automatic logic tag_wake(input logic             rdy,
                                    input logic [TAG_W-1:0] tag,
                                    input logic             bc_flag,
                                    input logic [TAG_W-1:0] bc_map);
    return bc_flag && !rdy && (tag == bc_map);
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Age matrix (row i bit j set: entry i is older than entry j) and
// oldest-ready one-hot select.
module iq_age_select
  import iq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_c_o
);

  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic [DEPTH-1:0]            blocked_c;

  // A new entry is younger than every other slot.
  always_comb begin
    age_d = age_q;
    if (alloc_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[alloc_idx_i][j] = 1'b0;
        age_d[j][alloc_idx_i] = (IDX_W'(j) != alloc_idx_i);
      end
    end
  end

  always_comb begin
    blocked_c = '0;
    grant_c_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((i != j) && ready_i[j] && age_q[j][i]) begin
          blocked_c[i] = 1'b1;
        end
      end
      grant_c_o[i] = ready_i[i] && !blocked_c[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue window feeding EXE; oldest ready entry issues each cycle.
// Optional ISSUE_BYPASS_EN: same-cycle broadcast makes a dependent entry selectable.
module issue_queue
  import iq_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [31:0]       disp_instr,
  input  logic [31:0]       disp_pc,
  input  logic [TAG_W-1:0]  disp_a_tag,
  input  logic [TAG_W-1:0]  disp_b_tag,
  input  logic              disp_a_rdy,
  input  logic              disp_b_rdy,
  input  logic [31:0]       disp_a_val,
  input  logic [31:0]       disp_b_val,
  input  logic [TAG_W-1:0]  disp_dest_map,
  input  logic [4:0]        disp_wreg,
  input  logic              disp_regwr,
  input  logic              disp_memrd,
  input  logic              disp_memwr,
  input  logic [5:0]        disp_alu_ctl,
  input  logic [4:0]        disp_shamt,
  input  logic [INFO_W-1:0] disp_info,
  input  logic              bc_flag,
  input  logic [TAG_W-1:0]  bc_map,
  input  logic [31:0]       bc_val,
  output logic              iss_valid,
  output logic [31:0]       Instr1_OUT,
  output logic [31:0]       Instr1_PC_OUT,
  output logic [31:0]       OperandA1_OUT,
  output logic [31:0]       OperandB1_OUT,
  output logic [31:0]       MemWriteData1_OUT,
  output logic [4:0]        WriteRegister1_OUT,
  output logic              RegWrite1_OUT,
  output logic [5:0]        ALU_Control1_OUT,
  output logic [4:0]        ShiftAmount1_OUT,
  output logic              MemRead1_OUT,
  output logic              MemWrite1_OUT,
  output logic [INFO_W-1:0] all_info_OUT,
  output logic [TAG_W-1:0]  RegWr_map_OUT,
  output logic              RegWr_flag_OUT
);

  iq_entry_t        ent_q [DEPTH];
  iq_entry_t        ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             disp_ready_q, disp_ready_d;
  iq_issue_t        iss_q, iss_d;

  logic [DEPTH-1:0] a_wake_c, b_wake_c, ready_c, grant_c;
  logic [IDX_W-1:0] free_idx_c;
  logic             free_ok_c, accept_c, issue_c;
  iq_entry_t        new_ent_c;

  // Source wakeup and per-entry readiness.
  always_comb begin
    a_wake_c = '0;
    b_wake_c = '0;
    ready_c  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a_wake_c[i] = ent_q[i].valid && tag_wake(ent_q[i].a_rdy, ent_q[i].a_tag, bc_flag, bc_map);
      b_wake_c[i] = ent_q[i].valid && tag_wake(ent_q[i].b_rdy, ent_q[i].b_tag, bc_flag, bc_map);
`ifdef ISSUE_BYPASS_EN
      ready_c[i]  = ent_q[i].valid && (ent_q[i].a_rdy || a_wake_c[i])
                                   && (ent_q[i].b_rdy || b_wake_c[i]);
`else
      ready_c[i]  = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
`endif
    end
  end

  // Lowest free slot for allocation.
  always_comb begin
    free_idx_c = '0;
    free_ok_c  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_ok_c && !ent_q[i].valid) begin
        free_idx_c = IDX_W'(i);
        free_ok_c  = 1'b1;
      end
    end
  end

  assign accept_c = disp_valid && disp_ready_q && free_ok_c && !flush;
  assign issue_c  = |grant_c;

  iq_age_select u_age_select (
    .clk         (CLK),
    .rst_n       (RESET),
    .alloc_i     (accept_c),
    .alloc_idx_i (free_idx_c),
    .ready_i     (ready_c),
    .grant_c_o   (grant_c)
  );

  // Incoming entry also captures a same-cycle broadcast on its sources.
  always_comb begin
    new_ent_c          = '0;
    new_ent_c.valid    = 1'b1;
    new_ent_c.instr    = disp_instr;
    new_ent_c.pc       = disp_pc;
    new_ent_c.a_tag    = disp_a_tag;
    new_ent_c.b_tag    = disp_b_tag;
    new_ent_c.a_rdy    = disp_a_rdy || tag_wake(disp_a_rdy, disp_a_tag, bc_flag, bc_map);
    new_ent_c.b_rdy    = disp_b_rdy || tag_wake(disp_b_rdy, disp_b_tag, bc_flag, bc_map);
    new_ent_c.a_val    = tag_wake(disp_a_rdy, disp_a_tag, bc_flag, bc_map) ? bc_val : disp_a_val;
    new_ent_c.b_val    = tag_wake(disp_b_rdy, disp_b_tag, bc_flag, bc_map) ? bc_val : disp_b_val;
    new_ent_c.dest_map = disp_dest_map;
    new_ent_c.wreg     = disp_wreg;
    new_ent_c.regwr    = disp_regwr;
    new_ent_c.memrd    = disp_memrd;
    new_ent_c.memwr    = disp_memwr;
    new_ent_c.alu_ctl  = disp_alu_ctl;
    new_ent_c.shamt    = disp_shamt;
    new_ent_c.info     = disp_info;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    count_d = count_q;
    iss_d   = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
      end
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a_wake_c[i]) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = bc_val;
        end
        if (b_wake_c[i]) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = bc_val;
        end
        if (grant_c[i]) begin
          ent_d[i].valid = 1'b0;
          iss_d.valid    = 1'b1;
          iss_d.instr    = ent_q[i].instr;
          iss_d.pc       = ent_q[i].pc;
`ifdef ISSUE_BYPASS_EN
          iss_d.opa      = ent_q[i].a_rdy ? ent_q[i].a_val : bc_val;
          iss_d.opb      = ent_q[i].b_rdy ? ent_q[i].b_val : bc_val;
`else
          iss_d.opa      = ent_q[i].a_val;
          iss_d.opb      = ent_q[i].b_val;
`endif
          iss_d.wreg     = ent_q[i].wreg;
          iss_d.regwr    = ent_q[i].regwr;
          iss_d.alu_ctl  = ent_q[i].alu_ctl;
          iss_d.shamt    = ent_q[i].shamt;
          iss_d.memrd    = ent_q[i].memrd;
          iss_d.memwr    = ent_q[i].memwr;
          iss_d.info     = ent_q[i].info;
          iss_d.map      = ent_q[i].dest_map;
          iss_d.flag     = ent_q[i].regwr;
        end
      end
      if (accept_c) begin
        ent_d[free_idx_c] = new_ent_c;
      end
      if (accept_c && !issue_c && (count_q != CNT_W'(DEPTH))) begin
        count_d = count_q + CNT_W'(1);
      end else if (!accept_c && issue_c && (count_q != '0)) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  assign disp_ready_d = (count_d != CNT_W'(DEPTH));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q      <= '0;
      disp_ready_q <= 1'b1;
      iss_q        <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q      <= count_d;
      disp_ready_q <= disp_ready_d;
      iss_q        <= iss_d;
    end
  end

  assign disp_ready         = disp_ready_q;
  assign iss_valid          = iss_q.valid;
  assign Instr1_OUT         = iss_q.instr;
  assign Instr1_PC_OUT      = iss_q.pc;
  assign OperandA1_OUT      = iss_q.opa;
  assign OperandB1_OUT      = iss_q.opb;
  assign MemWriteData1_OUT  = iss_q.opb;
  assign WriteRegister1_OUT = iss_q.wreg;
  assign RegWrite1_OUT      = iss_q.regwr;
  assign ALU_Control1_OUT   = iss_q.alu_ctl;
  assign ShiftAmount1_OUT   = iss_q.shamt;
  assign MemRead1_OUT       = iss_q.memrd;
  assign MemWrite1_OUT      = iss_q.memwr;
  assign all_info_OUT       = iss_q.info;
  assign RegWr_map_OUT      = iss_q.map;
  assign RegWr_flag_OUT     = iss_q.flag;

endmodule
